// File: rtl/clock12_pkg.sv
// clock12_pkg: shared widths, limits, time record and handshake states for the 12-hour timekeeper
package clock12_pkg;
    localparam int HOUR_W = 4;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam logic [MIN_W-1:0]  MAX_MS   = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_TOP = 4'd12;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
        logic [SEC_W-1:0]  second;
        logic              pm;
    } time_t;

    typedef enum logic {IDLE, RESP} hs_state_t;

    function automatic logic valid_time(input time_t t);
        return t.hour != '0 && t.hour <= HOUR_TOP && t.minute <= MAX_MS && t.second <= MAX_MS;
    endfunction
endpackage

// File: rtl/mod_cnt_en.sv
// mod_cnt_en: modulo-MOD counter with enable, synchronous load and carry-out
//   clk, reset (async, active-high) | en: advance | ld/ld_val: load (wins over en)
//   q: count 0..MOD-1 | co: high while enabled at MOD-1 (wrap on this edge)
module mod_cnt_en #(
    parameter int MOD = 60,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] q,
    output logic         co
);
    assign co = en && (q == W'(MOD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (ld)
            q <= ld_val;
        else if (en)
            q <= co ? '0 : q + 1'b1;
    end
endmodule

// File: rtl/clock12_timekeeper.sv
// clock12_timekeeper: 12-hour hh:mm:ss AM/PM keeper with 1 Hz prescaler and set handshake
//   clk, reset (async, active-high)
//   set_req/set_hour/set_min/set_sec/set_pm: level load request and fields
//   set_ack/set_err: 1-cycle accept/reject pulses
//   hour/minute/second/pm: registered current time
//   sec_pulse: 1-cycle pulse per second advance | day_roll: 11:59:59 PM -> 12:00:00 AM pulse
module clock12_timekeeper
    import clock12_pkg::*;
#(
    parameter int CLK_PER_SEC = 10,
    parameter int PS_WIDTH    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_req,
    input  logic [HOUR_W-1:0] set_hour,
    input  logic [MIN_W-1:0]  set_min,
    input  logic [SEC_W-1:0]  set_sec,
    input  logic              set_pm,
    output logic              set_ack,
    output logic              set_err,
    output logic [HOUR_W-1:0] hour,
    output logic [MIN_W-1:0]  minute,
    output logic [SEC_W-1:0]  second,
    output logic              pm,
    output logic              sec_pulse,
    output logic              day_roll
);
    hs_state_t st, nxt;
    time_t req;
    logic load, ack_d, err_d, ps_co, tick, adv, sec_co, min_co;
    logic [PS_WIDTH-1:0] ps;

    assign req = '{hour: set_hour, minute: set_min, second: set_sec, pm: set_pm};

    // A request is only sampled in IDLE, so a req still high during RESP cannot reload.
    always_comb begin
        nxt   = (st == IDLE && set_req) ? RESP : IDLE;
        load  = nxt == RESP && valid_time(req);
        ack_d = load;
        err_d = nxt == RESP && !load;
    end

    // A load restarts the second, so it swallows a tick landing on the same edge.
    assign tick = ps_co && ps == PS_WIDTH'(CLK_PER_SEC - 1);
    assign adv  = tick && !load;

    mod_cnt_en #(.MOD(CLK_PER_SEC), .W(PS_WIDTH)) u_ps (
        .clk(clk), .reset(reset), .en(1'b1), .ld(load), .ld_val('0), .q(ps), .co(ps_co)
    );

    mod_cnt_en #(.MOD(60), .W(SEC_W)) u_sec (
        .clk(clk), .reset(reset), .en(adv), .ld(load), .ld_val(set_sec), .q(second), .co(sec_co)
    );

    mod_cnt_en #(.MOD(60), .W(MIN_W)) u_min (
        .clk(clk), .reset(reset), .en(sec_co), .ld(load), .ld_val(set_min), .q(minute), .co(min_co)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= IDLE;
            set_ack   <= 1'b0;
            set_err   <= 1'b0;
            sec_pulse <= 1'b0;
            day_roll  <= 1'b0;
            hour      <= HOUR_TOP;
            pm        <= 1'b0;
        end else begin
            st        <= nxt;
            set_ack   <= ack_d;
            set_err   <= err_d;
            sec_pulse <= adv;
            day_roll  <= min_co && hour == 4'd11 && pm;
            if (load) begin
                hour <= set_hour;
                pm   <= set_pm;
            end else if (min_co) begin
                // 12 is the first hour of each half-day; reaching it from 11 flips AM/PM.
                hour <= (hour == HOUR_TOP) ? 4'd1 : hour + 1'b1;
                pm   <= pm ^ (hour == 4'd11);
            end
        end
    end
endmodule
